// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between two pipeline lanes.
// A lane request is captured into operand registers, issued with a one-cycle
// div_start pulse, and its result is held per lane until the lane advances or
// is flushed. A flush of the owning lane drains the in-flight division and
// discards its result.
// Optional statistics counters (stat_busy_cycles, stat_conflicts) are built
// only when the macro DIV_ARB_STAT_EN is defined.
module div_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  lane_req,
  input  logic [1:0]  lane_mod,
  input  logic [1:0]  lane_unsigned,
  input  logic [31:0] lane0_src1,
  input  logic [31:0] lane0_src2,
  input  logic [31:0] lane1_src1,
  input  logic [31:0] lane1_src2,
  input  logic [1:0]  lane_adv,
  input  logic [1:0]  lane_flush,
  output logic [1:0]  lane_ok,
  output logic [31:0] lane0_result,
  output logic [31:0] lane1_result,
  output logic        div_start,
  output logic        div_mod,
  output logic        div_unsigned,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  input  logic        div_done,
  input  logic [31:0] div_result
`ifdef DIV_ARB_STAT_EN
  ,
  output logic [31:0] stat_busy_cycles,
  output logic [31:0] stat_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [1:0]  done;
  logic [31:0] result [2];
  logic [1:0]  pending;
  logic        grant;
  logic        owner_flush;
  logic [1:0]  done_set;
  logic [1:0]  done_clr;

  // A lane may be arbitrated when it requests, has no unconsumed result,
  // is not being flushed, and is not the lane currently using the divider.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam logic LANE = 1'(gi);
    assign pending[gi] = lane_req[gi] && !done[gi] && !lane_flush[gi] &&
                         !((state != IDLE) && (owner == LANE));
  end

  assign owner_flush = lane_flush[owner];
  assign lane_ok      = done;
  assign lane0_result = result[0];
  assign lane1_result = result[1];

  // Round-robin on ties: the lane that was not granted last wins.
  always_comb begin
    grant = pending[1];
    if (&pending) grant = ~last_grant;
  end

  // Per-lane done set/clear; a flush takes priority over a completing result.
  always_comb begin
    done_set = 2'b00;
    if ((state == WAIT) && div_done && !owner_flush) done_set[owner] = 1'b1;
    done_clr = lane_adv | lane_flush;
  end

  // Arbiter FSM with registered divider issue outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      div_start    <= 1'b0;
      div_mod      <= 1'b0;
      div_unsigned <= 1'b0;
      div_src1     <= 32'h0;
      div_src2     <= 32'h0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            owner        <= grant;
            last_grant   <= grant;
            div_src1     <= grant ? lane1_src1 : lane0_src1;
            div_src2     <= grant ? lane1_src2 : lane0_src2;
            div_mod      <= lane_mod[grant];
            div_unsigned <= lane_unsigned[grant];
            div_start    <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= owner_flush ? DRAIN : WAIT;
        WAIT: begin
          // a completion that coincides with an owner flush is simply dropped
          if (div_done)         state <= IDLE;
          else if (owner_flush) state <= DRAIN;
        end
        DRAIN: if (div_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane done flags and held results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done      <= 2'b00;
      result[0] <= 32'h0;
      result[1] <= 32'h0;
    end else begin
      done <= (done & ~done_clr) | done_set;
      for (int i = 0; i < 2; i++) begin
        if (done_set[i]) result[i] <= div_result;
      end
    end
  end

`ifdef DIV_ARB_STAT_EN
  // Busy-cycle and contested-IDLE-cycle counters, free-running and wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_busy_cycles <= 32'h0;
      stat_conflicts   <= 32'h0;
    end else begin
      if (state != IDLE) stat_busy_cycles <= stat_busy_cycles + 32'd1;
      if ((state == IDLE) && (&pending)) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
